// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered UART transmitter, 8N1 frames; define UART_TX_PARITY_EN for 8E1
module uart_tx_fifo #(
  parameter int CLK_PER_BIT = 5208,
  parameter int FIFO_AW     = 4
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_tx_valid,
  input  logic [7:0]         i_tx_data,
  output logic               o_tx_ready,
  output logic               o_tx_bit,
  output logic               o_tx_busy,
  output logic               o_tx_done,
  output logic [FIFO_AW:0]   o_fifo_count
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int BW    = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [FIFO_AW:0] FULL_COUNT = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [BW-1:0]    BAUD_LAST  = BW'(CLK_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  state_t             state_q, state_d;
  logic [BW-1:0]      baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shreg_q, shreg_d;
  logic               line_q, line_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
  logic               parity_q, parity_d;
`endif

  logic       push;
  logic       pop;
  logic       baud_end;
  logic [7:0] head;

  assign o_tx_ready   = (count_q != FULL_COUNT);
  assign push         = i_tx_valid && o_tx_ready;
  assign baud_end     = (baud_q == BAUD_LAST);
  assign head         = mem[rd_ptr_q];
  assign o_tx_bit     = line_q;
  assign o_tx_busy    = busy_q;
  assign o_tx_done    = done_q;
  assign o_fifo_count = count_q;

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    line_d   = line_q;
    done_d   = 1'b0;
    pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        line_d = 1'b1;
        baud_d = '0;
        pop    = (count_q != '0);
      end
      S_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          line_d  = shreg_q[0];
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            line_d  = parity_q;
            state_d = S_PARITY;
`else
            line_d  = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            shreg_d = shreg_q >> 1;
            line_d  = shreg_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_end) begin
          baud_d  = '0;
          line_d  = 1'b1;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
`endif
      S_STOP: begin
        if (baud_end) begin
          baud_d  = '0;
          done_d  = 1'b1;
          line_d  = 1'b1;
          state_d = S_IDLE;
          pop     = (count_q != '0);
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        line_d  = 1'b1;
        baud_d  = '0;
        state_d = S_IDLE;
      end
    endcase

    // Both IDLE and end-of-STOP load the head byte and start a frame right away.
    if (pop) begin
      shreg_d  = head;
      line_d   = 1'b0;
      state_d  = S_START;
`ifdef UART_TX_PARITY_EN
      parity_d = ^head;
`endif
    end

    busy_d   = (state_d != S_IDLE);
    wr_ptr_d = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (FIFO_AW+1)'(1);
      2'b01:   count_d = count_q - (FIFO_AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (push) begin
      mem[wr_ptr_q] <= i_tx_data;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      line_q   <= 1'b1;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      line_q   <= line_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo with a line-decoding scoreboard
module tb_uart_tx_fifo;

  localparam int CPB = 4;
  localparam int AW  = 2;
`ifdef UART_TX_PARITY_EN
  localparam int FB  = 11;
`else
  localparam int FB  = 10;
`endif
  localparam int FP  = FB * CPB;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid;
  logic [7:0]    data;
  logic          ready;
  logic          tx_bit;
  logic          busy;
  logic          done;
  logic [AW:0]   count;

  uart_tx_fifo #(.CLK_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_tx_valid   (valid),
    .i_tx_data    (data),
    .o_tx_ready   (ready),
    .o_tx_bit     (tx_bit),
    .o_tx_busy    (busy),
    .o_tx_done    (done),
    .o_fifo_count (count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] sb[$];
  int         start_q[$];
  logic       par_q[$];
  int         frames   = 0;
  bit         mon_busy = 1'b0;
  bit         abort    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Receiver model: samples each bit at its midpoint and checks against the scoreboard.
  initial begin : monitor
    logic [7:0] b;
    logic [7:0] e;
    logic       p;
    logic       stop;
    p = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tx_bit === 1'b0) begin
        mon_busy = 1'b1;
        abort    = 1'b0;
        start_q.push_back(cyc);
        repeat (CPB / 2) @(negedge clk);
        chk("start_bit", 32'(tx_bit), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx_bit;
        end
`ifdef UART_TX_PARITY_EN
        repeat (CPB) @(negedge clk);
        p = tx_bit;
`endif
        repeat (CPB) @(negedge clk);
        stop = tx_bit;
        if (!abort) begin
          chk("stop_bit", 32'(stop), 32'd1);
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got %0h expected no frame", b);
          end else begin
            e = sb.pop_front();
            chk("rx_byte", 32'(b), 32'(e));
`ifdef UART_TX_PARITY_EN
            chk("rx_parity", 32'(p), 32'(^e));
            par_q.push_back(p);
`endif
          end
          frames++;
        end
        mon_busy = 1'b0;
      end
    end
  end

  task automatic push_one(input logic [7:0] d);
    valid = 1'b1;
    data  = d;
    if (ready) sb.push_back(d);
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while ((sb.size() != 0 || mon_busy || busy) && n < max) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= max) begin
      errors++;
      $display("FAIL wait_idle_timeout: got %0d cycles expected below %0d", n, max);
    end
  endtask

  typedef struct {
    logic        valid;
    logic [7:0]  data;
    logic        exp_ready;
    logic [AW:0] exp_count;
  } vec_t;

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got no finish expected finish before 300000");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t       vt[10];
    logic [10:0] fr;
    int         n;
    int         f0;

    vt[0] = '{1'b1, 8'h10, 1'b1, 3'd0};
    vt[1] = '{1'b1, 8'h11, 1'b1, 3'd1};
    vt[2] = '{1'b1, 8'h12, 1'b1, 3'd1};
    vt[3] = '{1'b1, 8'h13, 1'b1, 3'd2};
    vt[4] = '{1'b1, 8'h14, 1'b1, 3'd3};
    vt[5] = '{1'b1, 8'h15, 1'b0, 3'd4};
    vt[6] = '{1'b1, 8'h16, 1'b0, 3'd4};
    vt[7] = '{1'b1, 8'h17, 1'b0, 3'd4};
    vt[8] = '{1'b1, 8'h18, 1'b0, 3'd4};
    vt[9] = '{1'b1, 8'h19, 1'b0, 3'd4};

    rst   = 1'b1;
    valid = 1'b0;
    data  = 8'h00;
    repeat (3) @(posedge clk); #1;
    chk("reset_line",  32'(tx_bit), 32'd1);
    chk("reset_ready", 32'(ready),  32'd1);
    chk("reset_busy",  32'(busy),   32'd0);
    chk("reset_done",  32'(done),   32'd0);
    chk("reset_count", 32'(count),  32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single byte 0xA5: exact line waveform, done pulse and busy window.
`ifdef UART_TX_PARITY_EN
    fr = 11'b1_0_10100101_0;
`else
    fr = 11'b0_1_10100101_0;
`endif
    push_one(8'hA5);
    n = cyc;
    chk("latency_pre", 32'(tx_bit), 32'd1);
    for (int t = 1; t <= FP + 2; t++) begin
      @(posedge clk); #1;
      chk("a5_line", 32'(tx_bit), (t <= FP) ? 32'(fr[(t - 1) / CPB]) : 32'd1);
      chk("a5_done", 32'(done), (t == FP + 1) ? 32'd1 : 32'd0);
      chk("a5_busy", 32'(busy), (t <= FP) ? 32'd1 : 32'd0);
    end
    wait_idle(200);

    // Three bytes back to back: in-order decode and exact frame spacing.
    start_q.delete();
    push_one(8'h01);
    push_one(8'h80);
    push_one(8'hFF);
    wait_idle(400);
    chk("burst_frames", 32'(start_q.size()), 32'd3);
    if (start_q.size() == 3) begin
      chk("burst_gap0", 32'(start_q[1] - start_q[0]), 32'(FP));
      chk("burst_gap1", 32'(start_q[2] - start_q[1]), 32'(FP));
    end

    // Overflow with depth 4: vector table drives valid every cycle.
    f0 = frames;
    for (int i = 0; i < 10; i++) begin
      valid = vt[i].valid;
      data  = vt[i].data;
      chk("ovf_ready", 32'(ready), 32'(vt[i].exp_ready));
      chk("ovf_count", 32'(count), 32'(vt[i].exp_count));
      if (valid && ready) sb.push_back(data);
      @(posedge clk); #1;
    end
    valid = 1'b0;
    wait_idle(1000);
    chk("ovf_frames", 32'(frames - f0), 32'd5);

    // Push landing on the edge where STOP ends while one byte is queued.
    push_one(8'h3C);
    n = cyc;
    push_one(8'hC3);
    chk("pp_count_queued", 32'(count), 32'd1);
    while (cyc < n + FP) begin
      @(posedge clk); #1;
    end
    valid = 1'b1;
    data  = 8'h5A;
    if (ready) sb.push_back(data);
    chk("pp_stop_line", 32'(tx_bit), 32'd1);
    chk("pp_count_pre", 32'(count), 32'd1);
    @(posedge clk); #1;
    valid = 1'b0;
    chk("pp_count_post", 32'(count), 32'd1);
    chk("pp_no_gap",     32'(tx_bit), 32'd0);
    chk("pp_done",       32'(done),   32'd1);
    chk("pp_busy",       32'(busy),   32'd1);
    wait_idle(400);

    // Parity pair 0x07 / 0x03 and frame period.
    start_q.delete();
    par_q.delete();
    push_one(8'h07);
    push_one(8'h03);
    wait_idle(400);
    if (start_q.size() == 2) chk("par_period", 32'(start_q[1] - start_q[0]), 32'(FP));
    else chk("par_frames", 32'(start_q.size()), 32'd2);
`ifdef UART_TX_PARITY_EN
    chk("par_period_abs", 32'(start_q.size() == 2 ? start_q[1] - start_q[0] : 0), 32'd44);
    if (par_q.size() == 2) begin
      chk("par_07", 32'(par_q[0]), 32'd1);
      chk("par_03", 32'(par_q[1]), 32'd0);
    end else begin
      chk("par_count", 32'(par_q.size()), 32'd2);
    end
`endif

    // Asynchronous reset in the middle of a frame with bytes still queued.
    push_one(8'h55);
    push_one(8'hAA);
    push_one(8'h0F);
    repeat (10) @(posedge clk);
    #1;
    chk("mid_busy_before", 32'(busy), 32'd1);
    #3;
    abort = 1'b1;
    rst   = 1'b1;
    #1;
    chk("mid_reset_line",  32'(tx_bit), 32'd1);
    chk("mid_reset_count", 32'(count),  32'd0);
    chk("mid_reset_ready", 32'(ready),  32'd1);
    chk("mid_reset_busy",  32'(busy),   32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    f0 = frames;
    repeat (60) @(posedge clk);
    #1;
    chk("post_reset_frames", 32'(frames - f0), 32'd0);
    chk("post_reset_line",   32'(tx_bit), 32'd1);
    chk("post_reset_busy",   32'(busy),   32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
